// File: rtl/level_stack_pkg.sv
// Shared types and defaults for the preemption-level controller.
// Build option LEVEL_STACK_TAILCHAIN_EN is consumed in level_stack.sv.
package level_stack_pkg;

  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned NumLevelsDefault = 8;
  localparam logic [31:0] RaMagicDefault   = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    RUN,
    ENTER,
    EXIT
  } state_t;

  // Saved context at the default widths (3-bit level, 32-bit pc).
  typedef struct packed {
    logic [2:0]  level;
    logic [31:0] pc;
  } frame_t;

endpackage

// File: rtl/level_stack_if.sv
// Request/jump/redirect bundle between the core, interrupt controller and level_stack.
interface level_stack_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumLevels = 8
);
  localparam int unsigned IndexLevels = $clog2(NumLevels);

  logic                   stall;
  logic                   irqValid;
  logic [IndexLevels-1:0] irqLevel;
  logic [DataWidth-1:0]   irqVector;
  logic                   irqAck;
  logic [DataWidth-1:0]   pcIn;
  logic                   jumpValid;
  logic [DataWidth-1:0]   jumpTarget;
  logic [IndexLevels-1:0] level;
  logic                   writeRaEn;
  logic [DataWidth-1:0]   writeRaData;
  logic                   pcRedirectValid;
  logic [DataWidth-1:0]   pcRedirect;
  logic [IndexLevels-1:0] depth;
  logic                   retErr;

  modport master (
    output stall, irqValid, irqLevel, irqVector, pcIn, jumpValid, jumpTarget,
    input  irqAck, level, writeRaEn, writeRaData, pcRedirectValid, pcRedirect, depth, retErr
  );

  modport slave (
    input  stall, irqValid, irqLevel, irqVector, pcIn, jumpValid, jumpTarget,
    output irqAck, level, writeRaEn, writeRaData, pcRedirectValid, pcRedirect, depth, retErr
  );
endinterface

// File: rtl/level_stack_pc_lifo.sv
// LIFO of saved {level, resume pc} frames; top is the most recent push.
module pc_lifo #(
  parameter type         T      = logic,
  parameter int unsigned Depth  = 7,
  parameter int unsigned CountW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  T                  data,
  output T                  top,
  output logic [CountW-1:0] count
);

  T mem [Depth];

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (push && (count < CountW'(Depth))) begin
      mem[count] <= data;
      count      <= count + 1'b1;
    end else if (pop && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign top = (count == '0) ? T'('0) : mem[count - 1'b1];

endmodule

// File: rtl/level_stack.sv
// Preemption-level controller: enters/leaves handler levels and redirects fetch.
// Optional LEVEL_STACK_TAILCHAIN_EN lets a return chain directly into a pending irq.
module level_stack
  import level_stack_pkg::*;
#(
  parameter int unsigned          DataWidth = DataWidthDefault,
  parameter int unsigned          NumLevels = NumLevelsDefault,
  parameter logic [DataWidth-1:0] RaMagic   = DataWidth'(RaMagicDefault)
) (
  input logic          clk,
  input logic          reset,
  level_stack_if.slave bus
);

  localparam int unsigned IndexLevels = $clog2(NumLevels);
  localparam int unsigned StackDepth  = NumLevels - 1;

  typedef struct packed {
    logic [IndexLevels-1:0] level;
    logic [DataWidth-1:0]   pc;
  } slot_t;

  state_t                 state;
  logic [IndexLevels-1:0] level_q;
  logic                   write_ra_q;
  logic                   redirect_valid_q;
  logic [DataWidth-1:0]   redirect_q;
  logic                   ret_err_q;

  slot_t                  top;
  logic [IndexLevels-1:0] count;
  logic                   ret, run_go, full, chain, take_irq, do_ret, ack;

  assign ret    = bus.jumpValid && (bus.jumpTarget == RaMagic);
  assign run_go = reset && (state == RUN) && !bus.stall;
  assign full   = (count == IndexLevels'(StackDepth));

`ifdef LEVEL_STACK_TAILCHAIN_EN
  // Reuses the top frame: the handler we chain into returns to the same context.
  assign chain = run_go && ret && (count != '0) && bus.irqValid && (bus.irqLevel > top.level);
`else
  assign chain = 1'b0;
`endif

  assign take_irq = run_go && !ret && bus.irqValid && (bus.irqLevel > level_q) && !full;
  assign do_ret   = run_go && ret && (count != '0) && !chain;
  assign ack      = take_irq || chain;

  pc_lifo #(
    .T      (slot_t),
    .Depth  (StackDepth),
    .CountW (IndexLevels)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (take_irq),
    .pop   (do_ret),
    .data  ('{level: level_q, pc: bus.pcIn}),
    .top   (top),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= RUN;
      level_q          <= '0;
      write_ra_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_q       <= '0;
      ret_err_q        <= 1'b0;
    end else begin
      write_ra_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (ack) begin
            state            <= ENTER;
            level_q          <= bus.irqLevel;
            write_ra_q       <= 1'b1;
            redirect_valid_q <= 1'b1;
            redirect_q       <= bus.irqVector;
          end else if (do_ret) begin
            state            <= EXIT;
            level_q          <= top.level;
            redirect_valid_q <= 1'b1;
            redirect_q       <= top.pc;
          end else if (run_go && ret) begin
            ret_err_q <= 1'b1;
          end
        end
        ENTER, EXIT: state <= RUN;
        default:     state <= RUN;
      endcase
    end
  end

  assign bus.irqAck          = ack;
  assign bus.level           = level_q;
  assign bus.writeRaEn       = write_ra_q;
  assign bus.writeRaData     = RaMagic;
  assign bus.pcRedirectValid = redirect_valid_q;
  assign bus.pcRedirect      = redirect_q;
  assign bus.depth           = count;
  assign bus.retErr          = ret_err_q;

endmodule

// File: tb/tb_level_stack.sv
// Directed bench for level_stack: queue-based context model plus literal spot checks.
module tb_level_stack;
  import level_stack_pkg::*;

  localparam logic [31:0] MAGIC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  level_stack_if #(.DataWidth(32), .NumLevels(8)) bus ();

  level_stack #(
    .DataWidth (32),
    .NumLevels (8),
    .RaMagic   (MAGIC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: architectural context stack as a queue.
  frame_t      m_stack[$];
  logic [2:0]  m_level;
  logic        m_ret_err, m_wra, m_prv, m_valid = 1'b0;
  logic [31:0] m_redirect;

  function automatic logic m_ret();
    return bus.jumpValid && (bus.jumpTarget == MAGIC);
  endfunction

  function automatic logic exp_ack();
    if (!reset || m_prv || bus.stall || !bus.irqValid) return 1'b0;
    if (m_ret()) begin
`ifdef LEVEL_STACK_TAILCHAIN_EN
      return (m_stack.size() > 0) && (bus.irqLevel > m_stack[$].level);
`else
      return 1'b0;
`endif
    end
    return (bus.irqLevel > m_level) && (m_stack.size() < 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    frame_t f;
    logic   a;
    if (!reset) begin
      m_valid = 1'b1; m_level = '0; m_stack.delete();
      m_ret_err = 1'b0; m_wra = 1'b0; m_prv = 1'b0; m_redirect = '0;
    end else if (m_valid) begin
      a = exp_ack();
      if (m_prv) begin
        m_wra = 1'b0; m_prv = 1'b0;
      end else if (!bus.stall) begin
        if (a) begin
          if (!m_ret()) m_stack.push_back('{level: m_level, pc: bus.pcIn});
          m_level = bus.irqLevel; m_wra = 1'b1; m_prv = 1'b1; m_redirect = bus.irqVector;
        end else if (m_ret() && m_stack.size() > 0) begin
          f = m_stack.pop_back();
          m_level = f.level; m_prv = 1'b1; m_redirect = f.pc;
        end else if (m_ret()) begin
          m_ret_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && reset) begin
      chk("m_irqAck", 32'(bus.irqAck), 32'(exp_ack()));
      chk("m_level", 32'(bus.level), 32'(m_level));
      chk("m_depth", 32'(bus.depth), 32'(m_stack.size()));
      chk("m_retErr", 32'(bus.retErr), 32'(m_ret_err));
      chk("m_writeRaEn", 32'(bus.writeRaEn), 32'(m_wra));
      chk("m_writeRaData", bus.writeRaData, MAGIC);
      chk("m_pcRedirectValid", 32'(bus.pcRedirectValid), 32'(m_prv));
      if (m_prv) chk("m_pcRedirect", bus.pcRedirect, m_redirect);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic irq(input logic v, input logic [2:0] l, input logic [31:0] vec, input logic [31:0] pc);
    bus.irqValid = v; bus.irqLevel = l; bus.irqVector = vec; bus.pcIn = pc;
  endtask

  task automatic jump(input logic v, input logic [31:0] t);
    bus.jumpValid = v; bus.jumpTarget = t;
  endtask

  task automatic ret_once();
    jump(1'b1, MAGIC);
    cyc();
    jump(1'b0, '0);
    cyc();
  endtask

  initial begin
    bus.stall = 1'b0;
    irq(1'b0, '0, '0, '0);
    jump(1'b0, '0);
    cyc(); cyc();
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_retErr", 32'(bus.retErr), 0);
    chk("rst_strobes", {29'd0, bus.irqAck, bus.writeRaEn, bus.pcRedirectValid}, 0);
    reset = 1'b1;

    // First entry from thread mode.
    irq(1'b1, 3'd1, 32'h100, 32'h40); #1;
    chk("enter_ack", 32'(bus.irqAck), 1);
    cyc(); #1;
    chk("enter_level", 32'(bus.level), 1);
    chk("enter_wra", 32'(bus.writeRaEn), 1);
    chk("enter_wrd", bus.writeRaData, MAGIC);
    chk("enter_redirect", bus.pcRedirect, 32'h100);
    chk("enter_ack_off", 32'(bus.irqAck), 0);
    irq(1'b0, '0, '0, 32'h104);
    cyc();

    irq(1'b1, 3'd3, 32'h200, 32'h108); cyc(); #1;
    chk("nest_depth", 32'(bus.depth), 2);
    chk("nest_level", 32'(bus.level), 3);
    irq(1'b0, '0, '0, 32'h204); cyc();

    // Equal/lower level is not accepted; stall holds a higher one off.
    irq(1'b1, 3'd2, 32'h250, 32'h208); #1;
    chk("lower_noack", 32'(bus.irqAck), 0);
    irq(1'b1, 3'd3, 32'h250, 32'h208); #1;
    chk("equal_noack", 32'(bus.irqAck), 0);
    cyc(); #1;
    chk("equal_level", 32'(bus.level), 3);
    bus.stall = 1'b1;
    irq(1'b1, 3'd5, 32'h300, 32'h20c); cyc(); cyc(); #1;
    chk("stall_noack", 32'(bus.irqAck), 0);
    chk("stall_level", 32'(bus.level), 3);
    bus.stall = 1'b0; #1;
    chk("unstall_ack", 32'(bus.irqAck), 1);
    cyc(); #1;
    chk("unstall_level", 32'(bus.level), 5);
    irq(1'b0, '0, '0, 32'h304); cyc();

    jump(1'b1, 32'h1234); cyc(); jump(1'b0, '0); #1;
    chk("plainjump_level", 32'(bus.level), 5);

    jump(1'b1, MAGIC); cyc(); #1;
    chk("ret1_level", 32'(bus.level), 3);
    chk("ret1_pc", bus.pcRedirect, 32'h20c);
    jump(1'b0, '0); cyc();
    jump(1'b1, MAGIC); cyc(); #1;
    chk("ret2_level", 32'(bus.level), 1);
    chk("ret2_pc", bus.pcRedirect, 32'h108);
    jump(1'b0, '0); cyc();
    jump(1'b1, MAGIC); cyc(); #1;
    chk("ret3_level", 32'(bus.level), 0);
    chk("ret3_pc", bus.pcRedirect, 32'h40);
    jump(1'b0, '0); cyc();

    // Return with nothing stacked.
    jump(1'b1, MAGIC); cyc(); #1;
    chk("reterr_set", 32'(bus.retErr), 1);
    chk("reterr_noredirect", 32'(bus.pcRedirectValid), 0);
    jump(1'b0, '0); cyc(); #1;
    chk("reterr_sticky", 32'(bus.retErr), 1);

    // Return and irq in the same cycle at depth 1.
    irq(1'b1, 3'd1, 32'h500, 32'h50); cyc();
    irq(1'b0, '0, '0, 32'h504); cyc();
    jump(1'b1, MAGIC);
    irq(1'b1, 3'd2, 32'h600, 32'h60); #1;
`ifdef LEVEL_STACK_TAILCHAIN_EN
    chk("chain_ack", 32'(bus.irqAck), 1);
    cyc(); #1;
    chk("chain_level", 32'(bus.level), 2);
    chk("chain_depth", 32'(bus.depth), 1);
    chk("chain_pc", bus.pcRedirect, 32'h600);
    jump(1'b0, '0); irq(1'b0, '0, '0, 32'h604); cyc();
`else
    chk("nochain_ack", 32'(bus.irqAck), 0);
    cyc(); #1;
    chk("nochain_level", 32'(bus.level), 0);
    chk("nochain_pc", bus.pcRedirect, 32'h50);
    jump(1'b0, '0); cyc(); #1;
    chk("after_exit_ack", 32'(bus.irqAck), 1);
    cyc(); #1;
    chk("after_exit_level", 32'(bus.level), 2);
    irq(1'b0, '0, '0, 32'h604); cyc();
`endif

    // Nest up to the top level, then unwind.
    for (int l = 3; l <= 7; l++) begin
      irq(1'b1, 3'(l), 32'h700 + 32'(l * 16), 32'h80 + 32'(l * 4));
      cyc();
      irq(1'b0, '0, '0, 32'h90);
      cyc();
    end
    chk("top_level", 32'(bus.level), 7);
    chk("top_depth", 32'(bus.depth), 6);
    irq(1'b1, 3'd7, 32'h800, 32'h94); #1;
    chk("top_noack", 32'(bus.irqAck), 0);
    irq(1'b0, '0, '0, 32'h94);
    for (int i = 0; i < 6; i++) ret_once();
    chk("unwind_level", 32'(bus.level), 0);
    chk("unwind_depth", 32'(bus.depth), 0);

    // Reset while entering discards the stack and error flag.
    irq(1'b1, 3'd4, 32'h900, 32'h98); cyc();
    reset = 1'b0;
    irq(1'b0, '0, '0, '0);
    cyc();
    reset = 1'b1; #1;
    chk("abort_level", 32'(bus.level), 0);
    chk("abort_depth", 32'(bus.depth), 0);
    chk("abort_retErr", 32'(bus.retErr), 0);
    chk("abort_redirect", 32'(bus.pcRedirectValid), 0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
